// File: rtl/cuberoot_sched.sv
// cuberoot_sched: round-robin front end that shares one iterative cube-root
// unit among N_REQ requesters. One operation is in flight at a time. The unit
// sees the operand magnitude and the scheduler restores the sign on the result.
//
// Build option: define CR_SPECIAL_BYPASS_EN so that +-0, +-Inf and NaN operands
// skip the unit and answer two cycles after the grant. A NaN answers with the
// canonical quiet NaN. When the macro is undefined, every operand takes the
// full LATENCY path.
module cuberoot_sched #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 34,
  parameter int W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic               cr_rst,
  output logic [W-1:0]       cr_data,
  input  logic [W-1:0]       cr_result,
  output logic               busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int EXP_W = 8;
  localparam int MAN_W = W - 1 - EXP_W;

  localparam logic [IDX_W:0]   N_REQ_X  = (IDX_W+1)'(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [W-1:0]     cr_data_q, cr_data_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [IDX_W:0]   probe;
  logic [IDX_W:0]   grant_next;
  logic [W-1:0]     grant_op;
  logic [N_REQ-1:0] owner_oh;

  // The unit always works on a non-negative operand, so its sign bit is never used.
  logic             cr_sign_unused;
  assign cr_sign_unused = cr_result[W-1];

  // Round-robin search: the first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    probe     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      probe = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (probe >= N_REQ_X) probe = probe - N_REQ_X;
      if (!grant_any && req_valid[probe[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = probe[IDX_W-1:0];
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Operand of the granted requester, and the pointer value just past it.
  always_comb begin
    grant_op = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) grant_op = req_data[k*W +: W];
    end
    grant_next = {1'b0, grant_idx} + (IDX_W+1)'(1);
    if (grant_next >= N_REQ_X) grant_next = '0;
  end

  // One-hot view of the owner, used to route the response.
  always_comb begin
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
  end

`ifdef CR_SPECIAL_BYPASS_EN
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [EXP_W-1:0] op_exp;
  logic [MAN_W-1:0] op_man;
  logic             op_nan;
  logic             op_special;

  assign op_exp     = cr_data_q[W-2 -: EXP_W];
  assign op_man     = cr_data_q[MAN_W-1:0];
  assign op_nan     = (&op_exp) && (|op_man);
  assign op_special = ((op_exp == '0) && (op_man == '0)) || (&op_exp);
`endif

  // Next-state and datapath-update logic for the IDLE/LOAD/RUN/RESP sequence.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    cr_data_d  = cr_data_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        // req_ready equals grant here, so any grant is a completed handshake.
        if (grant_any) begin
          owner_d   = grant_idx;
          rr_ptr_d  = grant_next[IDX_W-1:0];
          sign_d    = grant_op[W-1];
          cr_data_d = {1'b0, grant_op[W-2:0]};
          state_d   = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CNT_W'(1);
        state_d = RUN;
`ifdef CR_SPECIAL_BYPASS_EN
        if (op_special) begin
          rsp_data_d = op_nan ? QNAN : {sign_q, cr_data_q[W-2:0]};
          state_d    = RESP;
        end
`endif
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          rsp_data_d = {sign_q, cr_result[W-2:0]};
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      cr_data_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      cr_data_q  <= cr_data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // The grant is gated by reset so that requesters see no ready while reset is held.
  assign req_ready = (state_q == IDLE && rst) ? grant : '0;
  assign rsp_valid = (state_q == RESP) ? owner_oh : '0;
  assign rsp_data  = rsp_data_q;
  assign cr_rst    = (state_q == IDLE) || (state_q == LOAD);
  assign cr_data   = cr_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cuberoot_sched.sv
// tb_cuberoot_sched: directed test of the shared cube-root scheduler. It uses a
// small behavioural unit that produces a valid result only on the last RUN cycle
// and deliberately sets the result sign bit to 1.
module tb_cuberoot_sched;

  localparam int N = 4;
  localparam int L = 34;
  localparam int W = 32;
`ifdef CR_SPECIAL_BYPASS_EN
  localparam int BYP_LAT = 2;
`else
  localparam int BYP_LAT = L + 2;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '1;
  logic [W-1:0]   rsp_data;
  logic           cr_rst;
  logic [W-1:0]   cr_data;
  logic [W-1:0]   cr_result;
  logic           busy;

  int n_vec = 0;
  int n_bad = 0;
  int ucnt  = 0;

  cuberoot_sched #(.N_REQ(N), .LATENCY(L), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cr_rst(cr_rst), .cr_data(cr_data), .cr_result(cr_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural unit: counts cycles since its restart was released.
  function automatic logic [31:0] cbrt_tab(input logic [31:0] x);
    case (x)
      32'h41D8_0000: return 32'h4040_0000;  // 27 -> 3
      32'h4100_0000: return 32'h4000_0000;  // 8 -> 2
      32'h42FA_0000: return 32'h40A0_0000;  // 125 -> 5
      32'h0000_0000: return 32'h0000_0000;  // 0 -> 0
      32'h7F80_0001: return 32'h7FC0_0000;  // NaN -> qNaN
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cr_rst) ucnt <= 0;
    else        ucnt <= ucnt + 1;
  end

  assign cr_result = (!cr_rst && ucnt == L - 1) ? (cbrt_tab(cr_data) | 32'h8000_0000)
                                                : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] v);
    req_data[i*W +: W] = v;
  endtask

  // Runs one operation. The caller has already raised req_valid for the owner.
  // hold > 0 withholds the owner's rsp_ready for that many cycles after rsp_valid.
  // extra is OR-ed into req_valid right after the grant.
  task automatic run_op(input string tag, input int own, input logic [31:0] exp_cr,
                        input logic [31:0] exp_rsp, input int exp_lat,
                        input int hold, input logic [N-1:0] extra);
    int          n;
    logic [N-1:0] oh;
    logic [31:0] d0;
    logic        bad;
    oh = '0;
    oh[own] = 1'b1;
    rsp_ready = (hold > 0) ? ~oh : '1;
    @(negedge clk);
    chk({tag, "/idle"}, busy, 0);
    chk({tag, "/grant"}, req_ready, oh);
    @(posedge clk); #1;
    req_valid[own] = 1'b0;
    req_valid = req_valid | extra;
    @(negedge clk);
    chk({tag, "/load_rst"}, cr_rst, 1);
    chk({tag, "/cr_data"}, cr_data, exp_cr);
    n = 1;
    bad = 1'b0;
    while (rsp_valid == '0 && n < 200) begin
      if (req_ready != '0 || busy != 1'b1) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, n, exp_lat);
    chk({tag, "/rsp_valid"}, rsp_valid, oh);
    chk({tag, "/rsp_data"}, rsp_data, exp_rsp);
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== oh || rsp_data !== d0 || req_ready != '0) bad = 1'b1;
    end
    chk({tag, "/no_ready_busy"}, bad, 0);
    rsp_ready = '1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic bad;
    // Reset state, with requests pending to show that ready stays low.
    rst = 1'b0;
    req_valid = '1;
    repeat (2) @(negedge clk);
    chk("rst/req_ready", req_ready, 0);
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/rsp_data", rsp_data, 0);
    chk("rst/cr_rst", cr_rst, 1);
    chk("rst/cr_data", cr_data, 0);
    chk("rst/busy", busy, 0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Single request: 27.0 -> 3.0
    set_op(0, 32'h41D8_0000);
    req_valid = 4'b0001;
    run_op("single", 0, 32'h41D8_0000, 32'h4040_0000, L + 2, 0, '0);

    // Negative operand on requester 2: -8.0 -> -2.0
    set_op(2, 32'hC100_0000);
    req_valid = 4'b0100;
    run_op("neg", 2, 32'h4100_0000, 32'hC000_0000, L + 2, 0, '0);

    // Requester 3: 125.0 -> 5.0; the pointer wraps back to 0.
    set_op(3, 32'h42FA_0000);
    req_valid = 4'b1000;
    run_op("r3", 3, 32'h42FA_0000, 32'h40A0_0000, L + 2, 0, '0);

    // All four requesters valid: grants rotate 0,1,2,3.
    set_op(0, 32'h4100_0000);
    set_op(1, 32'h41D8_0000);
    set_op(2, 32'h42FA_0000);
    set_op(3, 32'h4100_0000);
    req_valid = 4'b1111;
    run_op("all0", 0, 32'h4100_0000, 32'h4000_0000, L + 2, 0, '0);
    run_op("all1", 1, 32'h41D8_0000, 32'h4040_0000, L + 2, 0, '0);
    run_op("all2", 2, 32'h42FA_0000, 32'h40A0_0000, L + 2, 0, '0);
    run_op("all3", 3, 32'h4100_0000, 32'h4000_0000, L + 2, 0, '0);

    // Backpressure on requester 1 for 10 cycles while requester 0 waits.
    set_op(1, 32'h4100_0000);
    set_op(0, 32'h41D8_0000);
    req_valid = 4'b0010;
    run_op("bp", 1, 32'h4100_0000, 32'h4000_0000, L + 2, 10, 4'b0001);
    run_op("bp_next", 0, 32'h41D8_0000, 32'h4040_0000, L + 2, 0, '0);

    // Reset pulse while RUN has count 10; the request stays raised throughout.
    set_op(2, 32'h41D8_0000);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mid/grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    repeat (11) @(negedge clk);
    chk("mid/running", cr_rst, 0);
    rst = 1'b0;
    #1;
    chk("mid/req_ready", req_ready, 0);
    chk("mid/rsp_valid", rsp_valid, 0);
    chk("mid/rsp_data", rsp_data, 0);
    chk("mid/cr_rst", cr_rst, 1);
    chk("mid/cr_data", cr_data, 0);
    chk("mid/busy", busy, 0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) bad = 1'b1;
    end
    chk("mid/no_rsp", bad, 0);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    run_op("after_rst", 2, 32'h41D8_0000, 32'h4040_0000, L + 2, 0, '0);

    // Special operands: -0.0 keeps its sign; NaN answers with the quiet NaN.
    set_op(0, 32'h8000_0000);
    req_valid = 4'b0001;
    run_op("negzero", 0, 32'h0000_0000, 32'h8000_0000, BYP_LAT, 0, '0);
    set_op(1, 32'h7F80_0001);
    req_valid = 4'b0010;
    run_op("nan", 1, 32'h7F80_0001, 32'h7FC0_0000, BYP_LAT, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
